coprocessor0: RTL
=================

COPROCESSOR0 -- requirements
Module: coprocessor0

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 wb_to_cp0  input  WBToCP0Data  fields: address_register[4:0], address_select[2:0], write_enabled, write_data[31:0], exception_valid, exception_address[31:0] (faulting PC), eret_flush, in_delay_slot, exception_code[4:0], is_address_fault, badvaddr_value[31:0].
REQ-005 hardware_interrupt  input  6  external interrupt lines, level-sensitive.
REQ-006 read_data  output  32  combinational read of the register at address_register/address_select.
REQ-007 cp0_to_if  output  CP0ToIFData  exception_address[31:0] redirect target; interrupt_valid[7:0] pending, enabled interrupts.

Function
REQ-008 Registers SHALL be implemented at (reg,sel): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0); any other address SHALL read 0 and ignore writes.
REQ-009 Status layout SHALL be StatusData: BEV bit22 constant 1; IM[15:8], EXL bit1, IE bit0 writable; all other bits read 0.
REQ-010 Cause layout SHALL be CauseData: BD bit31, TI bit30, IP[15:8], ExcCode[6:2]; only IP[9:8] (software) writable by mtc0; others read 0.
REQ-011 Cause.IP[15:10] SHALL register hardware_interrupt[5:0] every cycle; IP[15] = hardware_interrupt[5] OR TI.
REQ-012 Count SHALL increment by 1 every second cycle via an internal tick flop toggling each cycle; wraps 0xFFFFFFFF -> 0.
REQ-013 mtc0 to Count SHALL load write_data and override the increment in that cycle; tick unaffected.
REQ-014 TI SHALL set when an increment makes Count equal Compare; mtc0 to Compare SHALL load write_data and clear TI, clear winning over a same-cycle set.
REQ-015 On exception_valid: EXL<=1; ExcCode<=exception_code; if EXL was 0, EPC<=in_delay_slot ? exception_address-4 : exception_address and BD<=in_delay_slot; if EXL was 1, EPC and BD SHALL hold.
REQ-016 On exception_valid with is_address_fault=1, BadVAddr SHALL load badvaddr_value; otherwise BadVAddr holds.
REQ-017 On eret_flush, EXL SHALL clear to 0.
REQ-018 Priority SHALL be exception_valid > eret_flush > write_enabled; a lower-priority event in the same cycle SHALL be dropped entirely (no register write).
REQ-019 cp0_to_if.exception_address SHALL be 0xBFC00380 when exception_valid, current EPC when eret_flush, else 0 (combinational).
REQ-020 cp0_to_if.interrupt_valid SHALL equal Cause.IP & Status.IM when IE=1 and EXL=0, else 8'h00.
REQ-021 read_data SHALL reflect register state before the current edge (no write-through bypass).
REQ-022 EPC SHALL be writable by mtc0; BadVAddr SHALL be read-only.

Reset
REQ-023 On reset_n low: Status=0x00400000, Cause=0, Count=0, tick=0, Compare=0, EPC=0, BadVAddr=0, TI=0; assertion mid-operation SHALL take effect immediately, independent of clock.
REQ-024 During reset, read_data SHALL follow reset values and cp0_to_if.interrupt_valid SHALL be 8'h00.

Verification
REQ-025 Reset release, 10 cycles idle -> Count=5, Status read 0x00400000, Cause 0.
REQ-026 mtc0 Compare=0x10, Count=0x0E, Status=0x00008001 -> two increments later Cause.TI=1, interrupt_valid=8'h80; mtc0 Compare -> TI=0.
REQ-027 exception_valid, pc 0xBFC00100, in_delay_slot=1, code 4, is_address_fault=1, badvaddr 0x1233 -> EPC=0xBFC000FC, BD=1, ExcCode=4, BadVAddr=0x1233, EXL=1, exception_address=0xBFC00380.
REQ-028 Second exception while EXL=1, pc 0xBFC00200 -> EPC stays 0xBFC000FC; eret_flush -> exception_address=0xBFC000FC, EXL=0.
REQ-029 Same cycle exception_valid + mtc0 Status=0x0000FF01 -> Status IM unchanged, EXL=1; same cycle Count write at tick -> Count equals written value.
REQ-030 reset_n asserted between edges with Count=0x1234 -> Count reads 0 before next edge.

Source files
------------

// File: rtl/coprocessor0.sv
// coprocessor0: MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC) with exception/eret handling.
// Ports: clock, reset_n (async active-low); wb_to_cp0 (mtc0 write + exception/eret from writeback);
// hardware_interrupt[5:0] level lines; read_data (mfc0 read, pre-edge state);
// cp0_to_if (redirect target and pending enabled interrupts).
package cp0_pkg;
    typedef struct packed {
        logic [4:0]  address_register;
        logic [2:0]  address_select;
        logic        write_enabled;
        logic [31:0] write_data;
        logic        exception_valid;
        logic [31:0] exception_address;
        logic        eret_flush;
        logic        in_delay_slot;
        logic [4:0]  exception_code;
        logic        is_address_fault;
        logic [31:0] badvaddr_value;
    } wb_to_cp0_data_t;
    typedef struct packed {
        logic [31:0] exception_address;
        logic [7:0]  interrupt_valid;
    } cp0_to_if_data_t;
endpackage

module coprocessor0 import cp0_pkg::*; (
    input  logic            clock,
    input  logic            reset_n,
    input  wb_to_cp0_data_t wb_to_cp0,
    input  logic [5:0]      hardware_interrupt,
    output logic [31:0]     read_data,
    output cp0_to_if_data_t cp0_to_if
);
    logic [31:0] badvaddr, count, compare, epc;
    logic        tick, ti, bd, exl, ie;
    logic [7:0]  im;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [7:0]  ip;
    logic [31:0] status, cause;
    logic        exc, eret, wr_en, sel0;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        inc;
    assign exc   = wb_to_cp0.exception_valid;
    assign eret  = wb_to_cp0.eret_flush;
    // Lower-priority events in the same cycle as an exception or eret are dropped.
    assign wr_en = wb_to_cp0.write_enabled & ~exc & ~eret;
    assign sel0  = wb_to_cp0.address_select == 3'd0;
    assign wr_count   = wr_en & sel0 & (wb_to_cp0.address_register == 5'd9);
    assign wr_compare = wr_en & sel0 & (wb_to_cp0.address_register == 5'd11);
    assign wr_status  = wr_en & sel0 & (wb_to_cp0.address_register == 5'd12);
    assign wr_cause   = wr_en & sel0 & (wb_to_cp0.address_register == 5'd13);
    assign wr_epc     = wr_en & sel0 & (wb_to_cp0.address_register == 5'd14);
    // A Count write overrides that cycle's increment, so it cannot raise TI.
    assign inc    = tick & ~wr_count;
    assign ip     = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause  = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};
    always_comb begin
        read_data = 32'b0;
        if (sel0)
            read_data = wb_to_cp0.address_register == 5'd8  ? badvaddr :
                        wb_to_cp0.address_register == 5'd9  ? count    :
                        wb_to_cp0.address_register == 5'd11 ? compare  :
                        wb_to_cp0.address_register == 5'd12 ? status   :
                        wb_to_cp0.address_register == 5'd13 ? cause    :
                        wb_to_cp0.address_register == 5'd14 ? epc      : 32'b0;
        cp0_to_if.exception_address = exc ? 32'hBFC0_0380 : eret ? epc : 32'b0;
        cp0_to_if.interrupt_valid   = (ie & ~exl) ? (ip & im) : 8'h00;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            epc      <= '0;
            tick     <= 1'b0;
            ti       <= 1'b0;
            bd       <= 1'b0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            im       <= '0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
        end else begin
            tick  <= ~tick;
            ip_hw <= hardware_interrupt;
            count <= wr_count ? wb_to_cp0.write_data : count + {31'b0, tick};
            if (wr_compare)
                compare <= wb_to_cp0.write_data;
            ti <= wr_compare ? 1'b0 : (inc && (count + 32'd1 == compare)) ? 1'b1 : ti;
            if (wr_cause)
                ip_sw <= wb_to_cp0.write_data[9:8];
            if (exc) begin
                exl      <= 1'b1;
                exc_code <= wb_to_cp0.exception_code;
                if (!exl) begin
                    epc <= wb_to_cp0.in_delay_slot ? wb_to_cp0.exception_address - 32'd4
                                                   : wb_to_cp0.exception_address;
                    bd  <= wb_to_cp0.in_delay_slot;
                end
                if (wb_to_cp0.is_address_fault)
                    badvaddr <= wb_to_cp0.badvaddr_value;
            end else if (eret) begin
                exl <= 1'b0;
            end else begin
                if (wr_status) begin
                    im  <= wb_to_cp0.write_data[15:8];
                    exl <= wb_to_cp0.write_data[1];
                    ie  <= wb_to_cp0.write_data[0];
                end
                if (wr_epc)
                    epc <= wb_to_cp0.write_data;
            end
        end
    end
endmodule
